uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_if.sv | 39 +++
 rtl/uart_tx_arbiter.sv | 86 ++++++++
 tb/tb_uart_tx_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle joining two byte requesters, the arbiter and a UART transmitter.
interface uart_tx_arbiter_if;
    logic       cts;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_last;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_last;
    logic       req1_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic [1:0] grant;
    logic       timeout_err;

    modport master (
        output cts,
        output req0_valid, req0_data, req0_last,
        input  req0_ready,
        output req1_valid, req1_data, req1_last,
        input  req1_ready,
        input  tx_valid, tx_data,
        output tx_ready,
        input  grant, timeout_err
    );

    modport slave (
        input  cts,
        input  req0_valid, req0_data, req0_last,
        output req0_ready,
        input  req1_valid, req1_data, req1_last,
        output req1_ready,
        output tx_valid, tx_data,
        input  tx_ready,
        output grant, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter of two byte streams onto one UART transmitter,
// with a stall watchdog that revokes a grant whose owner stops offering bytes.
module uart_tx_arbiter #(
    parameter int unsigned TIMEOUT = 1023
) (
    input logic              clk,
    input logic              reset,
    uart_tx_arbiter_if.slave bus
);
    localparam logic [15:0] LIMIT = 16'(TIMEOUT);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, state_nx;
    logic        owner, owner_nx;
    logic        rptr, rptr_nx;
    logic [15:0] stall, stall_nx;

    logic        busy;
    logic        sel_valid;
    logic        sel_last;
    logic [7:0]  sel_data;
    logic        link_ok;
    logic        xfer;
    logic        expired;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            owner <= 1'b0;
            rptr  <= 1'b0;
            stall <= '0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            rptr  <= rptr_nx;
            stall <= stall_nx;
        end
    end

    // Owner's stream is passed straight through; the other side is ignored.
    always_comb begin
        busy      = (state == BUSY);
        sel_valid = owner ? bus.req1_valid : bus.req0_valid;
        sel_last  = owner ? bus.req1_last  : bus.req0_last;
        sel_data  = owner ? bus.req1_data  : bus.req0_data;
        link_ok   = busy && bus.cts;
        xfer      = link_ok && sel_valid && bus.tx_ready;
        expired   = busy && (stall == LIMIT) && !xfer;

        bus.tx_valid    = link_ok && sel_valid;
        bus.tx_data     = busy ? sel_data : 8'h00;
        bus.req0_ready  = link_ok && !owner && bus.tx_ready;
        bus.req1_ready  = link_ok && owner && bus.tx_ready;
        bus.grant       = busy ? (owner ? 2'b10 : 2'b01) : 2'b00;
        bus.timeout_err = expired;
    end

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        rptr_nx  = rptr;
        stall_nx = stall;
        unique case (state)
            IDLE: begin
                stall_nx = '0;
                if (bus.req0_valid || bus.req1_valid) begin
                    state_nx = BUSY;
                    owner_nx = (bus.req0_valid && bus.req1_valid) ?
                               rptr : bus.req1_valid;
                end
            end
            BUSY: begin
                // Only an idle owner with an open link counts as a stall.
                if (xfer)
                    stall_nx = '0;
                else if (bus.cts && !sel_valid)
                    stall_nx = stall + 16'd1;
                if ((xfer && sel_last) || expired) begin
                    state_nx = IDLE;
                    rptr_nx  = !owner;
                end
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queue-fed requesters, per-cycle reference
// model comparison and hand-computed expectations for each scenario.
module tb_uart_tx_arbiter;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic reset;

    uart_tx_arbiter_if bus();

    uart_tx_arbiter #(.TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [7:0] log_b[$];
    int         log_c[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         terr_n = 0;
    int         terr_c = -1;

    int m_owner = -1;
    int m_rptr = 0;
    int m_stall = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic present();
        bus.req0_valid = q0.size() > 0;
        bus.req0_data  = q0.size() > 0 ? q0[0][7:0] : 8'h00;
        bus.req0_last  = q0.size() > 0 ? q0[0][8] : 1'b0;
        bus.req1_valid = q1.size() > 0;
        bus.req1_data  = q1.size() > 0 ? q1[0][7:0] : 8'h00;
        bus.req1_last  = q1.size() > 0 ? q1[0][8] : 1'b0;
    endtask

    // Reference: owner -1 means idle; packets are granted whole, round robin.
    task automatic model_step();
        bit         v[2];
        bit         l[2];
        logic [7:0] d[2];
        bit   [1:0] e_rdy;
        logic [1:0] e_grant;
        bit         e_txv;
        logic [7:0] e_data;
        bit         e_terr;
        bit         fire;
        int         nxt;
        int         o;
        v[0] = bus.req0_valid; l[0] = bus.req0_last; d[0] = bus.req0_data;
        v[1] = bus.req1_valid; l[1] = bus.req1_last; d[1] = bus.req1_data;
        e_rdy = 2'b00; e_grant = 2'b00; e_txv = 0; e_data = 8'h00;
        e_terr = 0; fire = 0; nxt = m_owner;
        if (reset) begin
            nxt = -1; m_rptr = 0; m_stall = 0;
        end else if (m_owner < 0) begin
            m_stall = 0;
            if (v[0] || v[1])
                nxt = (v[0] && v[1]) ? m_rptr : (v[1] ? 1 : 0);
        end else begin
            o = m_owner;
            e_grant = (o == 0) ? 2'b01 : 2'b10;
            e_txv = v[o] && bus.cts;
            e_data = d[o];
            e_rdy[o] = bus.tx_ready && bus.cts;
            fire = e_txv && bus.tx_ready;
            e_terr = (m_stall == TMO) && !fire;
            if (fire) m_stall = 0;
            else if (bus.cts && !v[o]) m_stall++;
            if ((fire && l[o]) || e_terr) begin
                nxt = -1;
                m_rptr = 1 - o;
            end
        end
        check("grant", 32'(bus.grant), 32'(e_grant));
        check("tx_valid", 32'(bus.tx_valid), 32'(e_txv));
        check("tx_data", 32'(bus.tx_data), 32'(e_data));
        check("req0_ready", 32'(bus.req0_ready), 32'(e_rdy[0]));
        check("req1_ready", 32'(bus.req1_ready), 32'(e_rdy[1]));
        check("timeout_err", 32'(bus.timeout_err), 32'(e_terr));
        m_owner = nxt;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            model_step();
            if (bus.timeout_err) begin
                terr_n++;
                terr_c = cyc;
            end
            if (bus.tx_valid && bus.tx_ready) begin
                log_b.push_back(bus.tx_data);
                log_c.push_back(cyc);
            end
            if (bus.req0_valid && bus.req0_ready && q0.size() > 0)
                void'(q0.pop_front());
            if (bus.req1_valid && bus.req1_ready && q1.size() > 0)
                void'(q1.pop_front());
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            present();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sync_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_xfer(output int c);
        c = -1;
        for (int i = 0; i < 50; i++) begin
            sync_neg();
            if (bus.tx_valid && bus.tx_ready) begin
                c = cyc;
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_xfer: no transfer within 50 cycles");
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            sync_neg();
            if (q0.size() == 0 && q1.size() == 0 && bus.grant == 2'b00)
                return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL drain: traffic did not finish within 200 cycles");
    endtask

    task automatic check_log(input string name, input logic [7:0] exp[$]);
        check({name, " count"}, 32'(log_b.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < log_b.size(); i++)
            check($sformatf("%s byte %0d", name, i), 32'(log_b[i]), 32'(exp[i]));
    endtask

    initial begin
        int t;
        int t2;
        int terr_before;
        logic [7:0] exp_b[$];

        reset = 1'b1;
        bus.cts = 1'b1;
        bus.tx_ready = 1'b1;
        q0 = '{9'h0A0, 9'h1A1, 9'h0A2, 9'h1A3};
        q1 = '{9'h0B0, 9'h1B1, 9'h0B2, 9'h1B3};
        present();

        // Reset state with both requesters already valid
        sync_neg();
        check("rst grant", 32'(bus.grant), 32'd0);
        check("rst tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst tx_data", 32'(bus.tx_data), 32'd0);
        check("rst ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
        check("rst timeout_err", 32'(bus.timeout_err), 32'd0);
        tick();
        tick();
        reset = 1'b0;

        // Contention: alternate 0,1,0,1 with a one-cycle idle gap
        drain();
        exp_b = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hA2, 8'hA3, 8'hB2, 8'hB3};
        check_log("contention", exp_b);
        if (log_c.size() == 8) begin
            check("contention back-to-back", 32'(log_c[1] - log_c[0]), 32'd1);
            check("contention gap", 32'(log_c[2] - log_c[1]), 32'd2);
        end

        // Single packet
        log_b.delete(); log_c.delete();
        tick();
        q0 = '{9'h0A1, 9'h0B2, 9'h1C3};
        sync_neg();
        check("single idle grant", 32'(bus.grant), 32'd0);
        sync_neg();
        check("single grant", 32'(bus.grant), 32'd1);
        check("single byte1", 32'(bus.tx_data), 32'hA1);
        sync_neg();
        check("single byte2", 32'(bus.tx_data), 32'hB2);
        sync_neg();
        check("single byte3", 32'(bus.tx_data), 32'hC3);
        check("single valid3", 32'(bus.tx_valid), 32'd1);
        sync_neg();
        check("single release", 32'(bus.grant), 32'd0);

        // CTS pause for 5 cycles after byte 1
        log_b.delete(); log_c.delete();
        tick();
        q0 = '{9'h031, 9'h032, 9'h133};
        wait_xfer(t);
        tick();
        bus.cts = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sync_neg();
            check("pause tx_valid", 32'(bus.tx_valid), 32'd0);
            check("pause req0_ready", 32'(bus.req0_ready), 32'd0);
        end
        tick();
        bus.cts = 1'b1;
        drain();
        exp_b = '{8'h31, 8'h32, 8'h33};
        check_log("pause", exp_b);
        check("pause no timeout", 32'(terr_n), 32'd0);

        // Timeout: req1 sends one non-last byte then goes silent
        log_b.delete(); log_c.delete();
        tick();
        q1 = '{9'h044};
        wait_xfer(t);
        for (int i = 0; i < 20 && !bus.timeout_err; i++)
            sync_neg();
        check("timeout pulses", 32'(terr_n), 32'd1);
        check("timeout delay", 32'(terr_c - t), 32'(TMO + 1));
        sync_neg();
        check("timeout release", 32'(bus.grant), 32'd0);
        check("timeout one cycle", 32'(bus.timeout_err), 32'd0);
        log_b.delete(); log_c.delete();
        tick();
        q0 = '{9'h151};
        q1 = '{9'h161};
        drain();
        exp_b = '{8'h51, 8'h61};
        check_log("rptr after timeout", exp_b);

        // Last byte lands exactly when the stall count hits TIMEOUT
        log_b.delete(); log_c.delete();
        terr_before = terr_n;
        tick();
        q0 = '{9'h011};
        wait_xfer(t);
        for (int i = 0; i < 5; i++)
            tick();
        q0.push_back(9'h112);
        sync_neg();
        check("coincide cycle", 32'(cyc - t), 32'(TMO + 1));
        check("coincide valid", 32'(bus.tx_valid), 32'd1);
        check("coincide data", 32'(bus.tx_data), 32'h12);
        check("coincide no err", 32'(bus.timeout_err), 32'd0);
        sync_neg();
        check("coincide release", 32'(bus.grant), 32'd0);
        check("coincide err count", 32'(terr_n), 32'(terr_before));

        // Reset asserted after byte 2 of 4
        log_b.delete(); log_c.delete();
        tick();
        q0 = '{9'h081, 9'h082, 9'h083, 9'h184};
        wait_xfer(t);
        wait_xfer(t2);
        check("midrst byte2", 32'(log_b.size()), 32'd2);
        reset = 1'b1;
        q0.delete();
        #1;
        check("midrst grant", 32'(bus.grant), 32'd0);
        check("midrst tx_valid", 32'(bus.tx_valid), 32'd0);
        check("midrst tx_data", 32'(bus.tx_data), 32'd0);
        check("midrst ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        log_b.delete(); log_c.delete();
        tick();
        q1 = '{9'h071, 9'h172};
        sync_neg();
        check("postrst idle", 32'(bus.grant), 32'd0);
        sync_neg();
        check("postrst grant", 32'(bus.grant), 32'd2);
        drain();
        exp_b = '{8'h71, 8'h72};
        check_log("postrst", exp_b);

        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
